pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_redirect_queue.sv | 46 ++++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared pipeline package for the PC sequencer: default widths, vectors,
// FSM state encoding and a small state-decode helper.
package pc_sequencer_pkg;

  localparam int          PC_W_DEFAULT         = 16;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEFAULT   = 16'h0040;

  // Binary-encoded, 2-bit sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_REDIR = 2'd3
  } seq_state_e;

  // States in which pc_cur is a live fetch.
  function automatic logic is_fetch_state(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_REDIR);
  endfunction

  // States that squash IF/ID when entered.
  function automatic logic is_flush_state(input seq_state_e s);
    return (s == ST_REDIR);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of control inputs and fetch outputs of the PC sequencer.
//
// Handshake: the sequencer presents pc_cur with fetch_valid=1; the fetch is
// accepted on a rising edge where imem_ready=1 and stall=0, and only then does
// the PC move on. With imem_ready=0 or stall=1 the PC is held and fetch_valid
// drops on the following cycle until the hold condition is released.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);

  // Control side (hazard unit, branch unit, exception logic, imem).
  logic            stall;
  logic            imem_ready;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            exc;

  // Fetch side.
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_cur;
  logic            fetch_valid;
  logic            flush;

  // Debug visibility of the FSM and the pending-redirect register.
  seq_state_e      state_dbg;
  logic            pending_valid_dbg;
  logic [PC_W-1:0] pending_pc_dbg;

  modport master (
    output stall, imem_ready, br_taken, br_target, jmp, jmp_target, exc,
    input  pc_next, pc_cur, fetch_valid, flush,
    input  state_dbg, pending_valid_dbg, pending_pc_dbg
  );

  modport slave (
    input  stall, imem_ready, br_taken, br_target, jmp, jmp_target, exc,
    output pc_next, pc_cur, fetch_valid, flush,
    output state_dbg, pending_valid_dbg, pending_pc_dbg
  );

endinterface

// File: rtl/pc_redirect_queue.sv
// Single-entry pending-redirect register. A load overwrites any older
// pending target; a clear drops it. Clear wins if both are requested.
module pc_redirect_queue
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            clear,
  output logic            pending_valid,
  output logic [PC_W-1:0] pending_pc
);

  logic            pending_valid_d, pending_valid_q;
  logic [PC_W-1:0] pending_pc_d, pending_pc_q;

  // Next-state for the pending entry: clear drops validity, load overwrites.
  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_pc_d    = pending_pc_q;
    if (clear) begin
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_valid_d = 1'b1;
      pending_pc_d    = load_pc;
    end
  end

  // Pending entry storage, wiped by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_valid_q <= 1'b0;
      pending_pc_q    <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
    end
  end

  assign pending_valid = pending_valid_q;
  assign pending_pc    = pending_pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address from
// exception, branch, jump, hold and sequential sources, parks redirects that
// arrive while the front end is held, and squashes IF/ID on every redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEFAULT),
  parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.slave        bus
);

  seq_state_e      state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_cur_q;
  logic            fetch_valid_d, fetch_valid_q;
  logic            flush_d, flush_q;

  logic            go;
  logic [PC_W-1:0] redir_tgt;
  logic            pend_load;
  logic [PC_W-1:0] pend_load_pc;
  logic            pend_clear;
  logic            pending_valid;
  logic [PC_W-1:0] pending_pc;

  // The front end may move only when the hazard unit and imem both allow it.
  assign go = !bus.stall && bus.imem_ready;

  // Branch beats jump when both fire; the jump is dropped, not parked.
  assign redir_tgt = bus.br_taken ? bus.br_target : bus.jmp_target;

  pc_redirect_queue #(
    .PC_W (PC_W)
  ) u_redirect_queue (
    .clk           (clk),
    .rst           (rst),
    .load          (pend_load),
    .load_pc       (pend_load_pc),
    .clear         (pend_clear),
    .pending_valid (pending_valid),
    .pending_pc    (pending_pc)
  );

  // Next PC / next state selection in priority order:
  // exc, branch, jump, hold, pending redirect, sequential.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_cur_q;
    pend_load    = 1'b0;
    pend_load_pc = redir_tgt;
    pend_clear   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // First cycle after reset: present RESET_VECTOR, then start fetching it.
        state_d = ST_RUN;
      end
      default: begin
        if (bus.exc) begin
          pc_d       = EXC_VECTOR;
          state_d    = ST_REDIR;
          pend_clear = 1'b1;
        end else if (bus.br_taken || bus.jmp) begin
          if (go) begin
            pc_d       = redir_tgt;
            state_d    = ST_REDIR;
            pend_clear = 1'b1;
          end else begin
            // Front end is held: park the target, newest one wins.
            pend_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (!go) begin
          state_d = ST_HOLD;
        end else if ((state_q == ST_HOLD) && pending_valid) begin
          pc_d       = pending_pc;
          state_d    = ST_REDIR;
          pend_clear = 1'b1;
        end else begin
          // Sequential advance wraps naturally at 2^PC_W.
          pc_d    = pc_cur_q + PC_W'(1);
          state_d = ST_RUN;
        end
      end
    endcase
    fetch_valid_d = is_fetch_state(state_d);
    flush_d       = is_flush_state(state_d);
  end

  // Sequencer FSM with registered PC, fetch_valid and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_cur_q      <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_cur_q      <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
    end
  end

  assign bus.pc_next           = pc_d;
  assign bus.pc_cur            = pc_cur_q;
  assign bus.fetch_valid       = fetch_valid_q;
  assign bus.flush             = flush_q;
  assign bus.state_dbg         = state_q;
  assign bus.pending_valid_dbg = pending_valid;
  assign bus.pending_pc_dbg    = pending_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random
// control traffic, all checked against a cycle-level reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [15:0] RV  = 16'h0000;
  localparam logic [15:0] EXV = 16'h0040;

  logic clk;
  logic rst;

  pc_sequencer_if #(.PC_W(16)) bus ();

  pc_sequencer #(
    .PC_W         (16),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EXV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: the model's predicted next PC, checked after the edge.
  logic [15:0] exp_q[$];

  // Reference model: current fetch view plus the parked redirect.
  logic        m_boot, m_live, m_flush, m_pend;
  logic [15:0] m_pc, m_pend_pc;
  logic        n_boot, n_live, n_flush, n_pend;
  logic [15:0] n_pc, n_pend_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Next cycle's view from the current view and this cycle's inputs.
  task automatic model_predict();
    logic        accept;
    logic [15:0] t;
    accept    = !bus.stall && bus.imem_ready;
    n_boot    = 1'b0;
    n_pc      = m_pc;
    n_live    = m_live;
    n_flush   = 1'b0;
    n_pend    = m_pend;
    n_pend_pc = m_pend_pc;
    if (m_boot) begin
      n_live = 1'b1;
    end else if (bus.exc) begin
      n_pc = EXV; n_pend = 1'b0; n_live = 1'b1; n_flush = 1'b1;
    end else if (bus.br_taken || bus.jmp) begin
      t = bus.br_taken ? bus.br_target : bus.jmp_target;
      if (accept) begin
        n_pc = t; n_pend = 1'b0; n_live = 1'b1; n_flush = 1'b1;
      end else begin
        n_pend = 1'b1; n_pend_pc = t; n_live = 1'b0;
      end
    end else if (!accept) begin
      n_live = 1'b0;
    end else if (m_pend) begin
      n_pc = m_pend_pc; n_pend = 1'b0; n_live = 1'b1; n_flush = 1'b1;
    end else begin
      n_pc = m_pc + 16'd1; n_live = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic stall, input logic ready, input logic br,
                       input logic [15:0] bt, input logic jmp,
                       input logic [15:0] jt, input logic exc);
    bus.stall      = stall;
    bus.imem_ready = ready;
    bus.br_taken   = br;
    bus.br_target  = bt;
    bus.jmp        = jmp;
    bus.jmp_target = jt;
    bus.exc        = exc;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  // One clock: check outputs mid-cycle, advance, check the landed PC.
  task automatic run_cycle();
    logic [15:0] exp_pc;
    @(negedge clk);
    model_predict();
    chk("pc_cur", bus.pc_cur, m_pc);
    chk("fetch_valid", bus.fetch_valid, m_live);
    chk("flush", bus.flush, m_flush);
    chk("pending_valid", bus.pending_valid_dbg, m_pend);
    if (m_pend) chk("pending_pc", bus.pending_pc_dbg, m_pend_pc);
    chk("pc_next", bus.pc_next, n_pc);
    exp_q.push_back(n_pc);
    @(posedge clk);
    #1;
    m_boot = n_boot; m_pc = n_pc; m_live = n_live; m_flush = n_flush;
    m_pend = n_pend; m_pend_pc = n_pend_pc;
    exp_pc = exp_q.pop_front();
    chk("pc_after_edge", bus.pc_cur, exp_pc);
  endtask

  // Asynchronous reset pulse starting mid-cycle, released just after an edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("rst_state", bus.state_dbg, ST_BOOT);
    chk("rst_pc_cur", bus.pc_cur, RV);
    chk("rst_fetch_valid", bus.fetch_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_pending_valid", bus.pending_valid_dbg, 1'b0);
    chk("rst_pending_pc", bus.pending_pc_dbg, 16'h0);
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_boot = 1'b1; m_pc = RV; m_live = 1'b0; m_flush = 1'b0;
    m_pend = 1'b0; m_pend_pc = 16'h0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] boot_pc [5];
    logic        boot_fv [5];
    boot_pc = '{16'h0, 16'h0, 16'h1, 16'h2, 16'h3};
    boot_fv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    drive_idle();
    do_reset();

    // Release from reset with no events.
    for (int i = 0; i < 5; i++) begin
      chk("boot_pc", bus.pc_cur, boot_pc[i]);
      chk("boot_fv", bus.fetch_valid, boot_fv[i]);
      run_cycle();
    end

    // Sequential wrap through 16'hFFFF.
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0);
    run_cycle();
    drive_idle();
    chk("wrap_fffe", bus.pc_cur, 16'hFFFE);
    run_cycle();
    chk("wrap_ffff", bus.pc_cur, 16'hFFFF);
    chk("wrap_ffff_flush", bus.flush, 1'b0);
    run_cycle();
    chk("wrap_0000", bus.pc_cur, 16'h0000);
    chk("wrap_0000_flush", bus.flush, 1'b0);

    // Stall at pc 5 for three cycles, branch to 0x20 in the second.
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0005, 1'b0);
    run_cycle();
    chk("hold_start_pc", bus.pc_cur, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, (i == 1), 16'h0020, 1'b0, 16'h0, 1'b0);
      run_cycle();
      chk("hold_pc", bus.pc_cur, 16'h0005);
      chk("hold_fv", bus.fetch_valid, 1'b0);
    end
    drive_idle();
    run_cycle();
    chk("hold_release_pc", bus.pc_cur, 16'h0020);
    chk("hold_release_flush", bus.flush, 1'b1);

    // Branch and jump together: branch wins, jump dropped.
    drive(1'b0, 1'b1, 1'b1, 16'h0030, 1'b1, 16'h0050, 1'b0);
    run_cycle();
    drive_idle();
    chk("br_jmp_pc", bus.pc_cur, 16'h0030);
    chk("br_jmp_flush", bus.flush, 1'b1);
    run_cycle();
    chk("br_jmp_no_queue", bus.pc_cur, 16'h0031);

    // Exception while stalled with a parked redirect.
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0);
    run_cycle();
    chk("exc_pend_set", bus.pending_valid_dbg, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    run_cycle();
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("exc_pc", bus.pc_cur, 16'h0040);
    chk("exc_pend_clear", bus.pending_valid_dbg, 1'b0);
    chk("exc_flush", bus.flush, 1'b1);
    run_cycle();

    // Reset in HOLD with a parked redirect.
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0);
    run_cycle();
    chk("rst_hold_pend", bus.pending_valid_dbg, 1'b1);
    do_reset();
    chk("post_rst_pc0", bus.pc_cur, 16'h0000);
    chk("post_rst_fv0", bus.fetch_valid, 1'b0);
    run_cycle();
    chk("post_rst_pc1", bus.pc_cur, 16'h0000);
    chk("post_rst_fv1", bus.fetch_valid, 1'b1);
    chk("post_rst_flush", bus.flush, 1'b0);

    // Random control traffic with periodic resets.
    for (int i = 0; i < 300; i++) begin
      if (i % 100 == 99) do_reset();
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 7) == 0), 16'($urandom),
            ($urandom_range(0, 7) == 0), 16'($urandom),
            ($urandom_range(0, 15) == 0));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
